// File: rtl/pong_round_sequencer.sv
// Pong game-level sequencer: serve/play/point/over flow, ball pacing, X steering and scoring.
// Optional build macro PONG_SPEEDUP_EN: paddle hits shorten the step interval down to MIN_DIV.
module pong_round_sequencer #(
  parameter int SCORE_W   = 4,
  parameter int WIN_SCORE = 9,
  parameter int STEP_DIV  = 4,
  parameter int DIV_W     = 4,
  parameter int MIN_DIV   = 2
) (
  input  logic               clk,
  input  logic               sim_rst,
  input  logic               frame_tick,
  input  logic               btn_fire,
  input  logic               col_esquerda,
  input  logic               col_direita,
  input  logic               miss_esquerda,
  input  logic               miss_direita,
  output logic               ball_reload,
  output logic               ball_step,
  output logic               ball_dir_x,
  output logic [SCORE_W-1:0] score_esq,
  output logic [SCORE_W-1:0] score_dir,
  output logic [2:0]         state,
  output logic               game_over,
  output logic               winner
);

  typedef enum logic [2:0] {
    IDLE  = 3'b000,
    SERVE = 3'b001,
    PLAY  = 3'b010,
    POINT = 3'b011,
    OVER  = 3'b100
  } state_t;

`ifdef PONG_SPEEDUP_EN
  localparam bit SPEEDUP = 1'b1;
`else
  localparam bit SPEEDUP = 1'b0;
`endif

  localparam logic [DIV_W-1:0]   INTERVAL_INIT  = DIV_W'(STEP_DIV - 1);
  localparam logic [DIV_W-1:0]   INTERVAL_FLOOR = DIV_W'(MIN_DIV - 1);
  localparam logic [SCORE_W-1:0] WIN_S          = SCORE_W'(WIN_SCORE);

  state_t             state_r, state_nx_s;
  logic               btn_q_r;
  logic               fire_s;
  logic [DIV_W-1:0]   div_r, div_nx_s;
  logic [DIV_W-1:0]   interval_r, interval_nx_s;
  logic [SCORE_W-1:0] score_esq_r, score_esq_nx_s;
  logic [SCORE_W-1:0] score_dir_r, score_dir_nx_s;
  logic               dir_r, dir_nx_s;
  logic               reload_r, reload_nx_s;
  logic               step_r, step_nx_s;
  logic               over_r, over_nx_s;
  logic               winner_r, winner_nx_s;
  logic               scorer_r, scorer_nx_s;   // 1 = right player took the last point

  assign fire_s = btn_fire & ~btn_q_r;

  // Next-state and next-value logic for every registered output.
  always_comb begin
    state_nx_s     = state_r;
    div_nx_s       = div_r;
    interval_nx_s  = interval_r;
    score_esq_nx_s = score_esq_r;
    score_dir_nx_s = score_dir_r;
    dir_nx_s       = dir_r;
    reload_nx_s    = 1'b0;
    step_nx_s      = 1'b0;
    over_nx_s      = over_r;
    winner_nx_s    = winner_r;
    scorer_nx_s    = scorer_r;
    case (state_r)
      IDLE: begin
        if (fire_s) begin
          state_nx_s     = SERVE;
          score_esq_nx_s = {SCORE_W{1'b0}};
          score_dir_nx_s = {SCORE_W{1'b0}};
          reload_nx_s    = 1'b1;
          interval_nx_s  = INTERVAL_INIT;
        end else begin
          state_nx_s = IDLE;
        end
      end
      SERVE: begin
        if (fire_s) begin
          state_nx_s = PLAY;
          div_nx_s   = {DIV_W{1'b0}};
        end else begin
          state_nx_s = SERVE;
        end
      end
      PLAY: begin
        // A miss ends the rally and overrides any collision in the same cycle.
        if (miss_esquerda) begin
          if (score_dir_r < WIN_S) begin
            score_dir_nx_s = score_dir_r + {{(SCORE_W-1){1'b0}}, 1'b1};
          end else begin
            score_dir_nx_s = score_dir_r;
          end
          dir_nx_s    = 1'b0;
          scorer_nx_s = 1'b1;
          state_nx_s  = POINT;
        end else if (miss_direita) begin
          if (score_esq_r < WIN_S) begin
            score_esq_nx_s = score_esq_r + {{(SCORE_W-1){1'b0}}, 1'b1};
          end else begin
            score_esq_nx_s = score_esq_r;
          end
          dir_nx_s    = 1'b1;
          scorer_nx_s = 1'b0;
          state_nx_s  = POINT;
        end else begin
          if (col_esquerda && !col_direita) begin
            dir_nx_s = 1'b1;
          end else if (col_direita && !col_esquerda) begin
            dir_nx_s = 1'b0;
          end else begin
            dir_nx_s = dir_r;
          end
          if (SPEEDUP && (col_esquerda || col_direita) && (interval_r > INTERVAL_FLOOR)) begin
            interval_nx_s = interval_r - {{(DIV_W-1){1'b0}}, 1'b1};
          end else begin
            interval_nx_s = interval_r;
          end
          // >= keeps pacing sane if the interval shrinks below a running divider.
          if (frame_tick) begin
            if (div_r >= interval_r) begin
              div_nx_s  = {DIV_W{1'b0}};
              step_nx_s = 1'b1;
            end else begin
              div_nx_s = div_r + {{(DIV_W-1){1'b0}}, 1'b1};
            end
          end else begin
            div_nx_s = div_r;
          end
        end
      end
      POINT: begin
        if ((scorer_r && (score_dir_r == WIN_S)) || (!scorer_r && (score_esq_r == WIN_S))) begin
          state_nx_s  = OVER;
          over_nx_s   = 1'b1;
          winner_nx_s = scorer_r;
        end else begin
          state_nx_s    = SERVE;
          reload_nx_s   = 1'b1;
          interval_nx_s = INTERVAL_INIT;
        end
      end
      OVER: begin
        if (fire_s) begin
          state_nx_s     = IDLE;
          score_esq_nx_s = {SCORE_W{1'b0}};
          score_dir_nx_s = {SCORE_W{1'b0}};
          over_nx_s      = 1'b0;
        end else begin
          state_nx_s = OVER;
        end
      end
      default: begin
        state_nx_s = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!sim_rst) begin
      state_r     <= IDLE;
      btn_q_r     <= 1'b1;
      div_r       <= {DIV_W{1'b0}};
      interval_r  <= INTERVAL_INIT;
      score_esq_r <= {SCORE_W{1'b0}};
      score_dir_r <= {SCORE_W{1'b0}};
      dir_r       <= 1'b1;
      reload_r    <= 1'b0;
      step_r      <= 1'b0;
      over_r      <= 1'b0;
      winner_r    <= 1'b0;
      scorer_r    <= 1'b0;
    end else begin
      state_r     <= state_nx_s;
      btn_q_r     <= btn_fire;
      div_r       <= div_nx_s;
      interval_r  <= interval_nx_s;
      score_esq_r <= score_esq_nx_s;
      score_dir_r <= score_dir_nx_s;
      dir_r       <= dir_nx_s;
      reload_r    <= reload_nx_s;
      step_r      <= step_nx_s;
      over_r      <= over_nx_s;
      winner_r    <= winner_nx_s;
      scorer_r    <= scorer_nx_s;
    end
  end

  assign state       = state_r;
  assign ball_reload = reload_r;
  assign ball_step   = step_r;
  assign ball_dir_x  = dir_r;
  assign score_esq   = score_esq_r;
  assign score_dir   = score_dir_r;
  assign game_over   = over_r;
  assign winner      = winner_r;

endmodule

// File: tb/tb_pong_round_sequencer.sv
// Directed bench for pong_round_sequencer (WIN_SCORE=3, STEP_DIV=4, MIN_DIV=2).
module tb_pong_round_sequencer;

  logic       clk = 1'b0;
  logic       sim_rst;
  logic       frame_tick, btn_fire;
  logic       col_esquerda, col_direita, miss_esquerda, miss_direita;
  logic       ball_reload, ball_step, ball_dir_x;
  logic [3:0] score_esq, score_dir;
  logic [2:0] state;
  logic       game_over, winner;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pong_round_sequencer #(
    .SCORE_W(4), .WIN_SCORE(3), .STEP_DIV(4), .DIV_W(4), .MIN_DIV(2)
  ) dut (
    .clk(clk), .sim_rst(sim_rst), .frame_tick(frame_tick), .btn_fire(btn_fire),
    .col_esquerda(col_esquerda), .col_direita(col_direita),
    .miss_esquerda(miss_esquerda), .miss_direita(miss_direita),
    .ball_reload(ball_reload), .ball_step(ball_step), .ball_dir_x(ball_dir_x),
    .score_esq(score_esq), .score_dir(score_dir), .state(state),
    .game_over(game_over), .winner(winner)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Release-then-press: fire is seen on the second edge.
  task automatic press();
    btn_fire = 1'b0;
    tick();
    btn_fire = 1'b1;
    tick();
    btn_fire = 1'b0;
  endtask

  // Continuous frame ticks; returns number of ticks up to and including the stepping one.
  task automatic gap(output int n);
    n = 0;
    frame_tick = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      n++;
      if (ball_step) break;
    end
    frame_tick = 1'b0;
  endtask

  // One rally lost by the right player, from PLAY through POINT.
  task automatic right_misses();
    miss_direita = 1'b1;
    tick();
    miss_direita = 1'b0;
    tick();
  endtask

  initial begin
    int steps;
    int g;
    int exp_g1, exp_g2, exp_g3;
    sim_rst = 1'b0; btn_fire = 1'b1; frame_tick = 1'b0;
    col_esquerda = 1'b0; col_direita = 1'b0; miss_esquerda = 1'b0; miss_direita = 1'b0;

    // Test 1: reset with button held, then press
    tick(); tick();
    chk("rst_state", state, 3'd0);
    chk("rst_sesq", score_esq, 4'd0);
    chk("rst_sdir", score_dir, 4'd0);
    chk("rst_dir", ball_dir_x, 1'b1);
    chk("rst_reload", ball_reload, 1'b0);
    chk("rst_step", ball_step, 1'b0);
    chk("rst_over", game_over, 1'b0);
    chk("rst_winner", winner, 1'b0);
    sim_rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("held_state", state, 3'd0);
      chk("held_reload", ball_reload, 1'b0);
    end
    btn_fire = 1'b0;
    tick();
    btn_fire = 1'b1;
    tick();
    chk("serve_state", state, 3'd1);
    chk("serve_reload", ball_reload, 1'b1);
    tick();
    chk("reload_once", ball_reload, 1'b0);
    chk("serve_hold", state, 3'd1);
    press();
    chk("play_state", state, 3'd2);

    // Test 2: 12 frame ticks -> step after ticks 4, 8, 12
    steps = 0;
    for (int k = 1; k <= 12; k++) begin
      frame_tick = 1'b1;
      tick();
      frame_tick = 1'b0;
      chk("step_after_tick", ball_step, (k % 4 == 0) ? 1'b1 : 1'b0);
      if (ball_step) steps++;
      tick();
      chk("step_one_cycle", ball_step, 1'b0);
    end
    chk("step_count", steps, 3);

    // Test 3: steering and miss-beats-collision
    col_direita = 1'b1;
    tick();
    chk("dir_right_hit", ball_dir_x, 1'b0);
    col_direita = 1'b0; col_esquerda = 1'b1;
    tick();
    chk("dir_left_hit", ball_dir_x, 1'b1);
    col_direita = 1'b1;
    tick();
    chk("dir_both_hit", ball_dir_x, 1'b1);
    col_direita = 1'b0; miss_esquerda = 1'b1;
    tick();
    col_esquerda = 1'b0; miss_esquerda = 1'b0;
    chk("miss_state", state, 3'd3);
    chk("miss_sdir", score_dir, 4'd1);
    chk("miss_dir", ball_dir_x, 1'b0);
    tick();
    chk("point_serve", state, 3'd1);
    chk("point_reload", ball_reload, 1'b1);

    // Test 4: three right-side misses end the game for the left player
    for (int r = 1; r <= 3; r++) begin
      press();
      right_misses();
      chk("round_sesq", score_esq, r);
      if (r < 3) begin
        chk("round_serve", state, 3'd1);
      end else begin
        chk("over_state", state, 3'd4);
        chk("over_flag", game_over, 1'b1);
        chk("over_winner", winner, 1'b0);
      end
    end
    miss_esquerda = 1'b1;
    tick();
    miss_esquerda = 1'b0;
    chk("over_ignore", score_dir, 4'd1);
    chk("over_hold", state, 3'd4);
    press();
    chk("restart_state", state, 3'd0);
    chk("restart_sesq", score_esq, 4'd0);
    chk("restart_sdir", score_dir, 4'd0);
    chk("restart_over", game_over, 1'b0);

    // Test 5: step spacing around paddle hits, then after a new serve
`ifdef PONG_SPEEDUP_EN
    exp_g1 = 3; exp_g2 = 2; exp_g3 = 2;
`else
    exp_g1 = 4; exp_g2 = 4; exp_g3 = 4;
`endif
    press();
    press();
    chk("p5_play", state, 3'd2);
    col_esquerda = 1'b1; tick(); col_esquerda = 1'b0;
    gap(g); chk("gap_hit1", g, exp_g1);
    col_direita = 1'b1; tick(); col_direita = 1'b0;
    gap(g); chk("gap_hit2", g, exp_g2);
    col_esquerda = 1'b1; tick(); col_esquerda = 1'b0;
    gap(g); chk("gap_hit3", g, exp_g3);
    right_misses();
    chk("p5_serve", state, 3'd1);
    press();
    gap(g); chk("gap_reserve", g, 4);

    // Test 6: reset mid-PLAY with a step about to fire
    right_misses();
    press();
    chk("p6_sesq", score_esq, 4'd2);
    chk("p6_play", state, 3'd2);
    frame_tick = 1'b1;
    tick(); tick(); tick();
    sim_rst = 1'b0;
    tick();
    frame_tick = 1'b0;
    chk("mid_rst_state", state, 3'd0);
    chk("mid_rst_sesq", score_esq, 4'd0);
    chk("mid_rst_step", ball_step, 1'b0);
    chk("mid_rst_dir", ball_dir_x, 1'b1);
    sim_rst = 1'b1;
    press();
    press();
    gap(g); chk("gap_after_rst", g, 4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
